// File: rtl/sonar_echo_detect.sv
// sonar_echo_detect: time-of-flight measurement on the FIR output stream.
// A measurement starts on start. The first blank samples are ignored. The
// block then waits for CONFIRM consecutive rectified samples at or above
// threshold. It reports the index of the first sample of that run, or
// all-ones on timeout.
// Optional feature: define ECHO_PEAK_EN to add the peak-amplitude output.
module sonar_echo_detect #(
  parameter int N       = 16,
  parameter int T       = 16,
  parameter int CONFIRM = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         en,
  input  logic [N-1:0] Y,
  input  logic [N-1:0] threshold,
  input  logic [T-1:0] blank,
  input  logic [T-1:0] timeout,
  output logic         busy,
  output logic         done,
  output logic         hit,
`ifdef ECHO_PEAK_EN
  output logic [N-1:0] peak,
`endif
  output logic [T-1:0] tof
);

  localparam int RW = $clog2(CONFIRM + 1);
  localparam logic [N-1:0] AMP_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] Y_MIN   = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SEARCH,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [T-1:0]  r_k;
  logic [RW-1:0] r_run;
  logic [T-1:0]  r_run_start;
  logic          r_busy;
  logic          r_done;
  logic          r_hit;
  logic [T-1:0]  r_tof;
`ifdef ECHO_PEAK_EN
  logic [N-1:0]  r_peak;
`endif

  // Rectifier. The most negative input has no positive counterpart, so it
  // clamps to the largest positive amplitude.
  logic [N-1:0]  w_y_neg;
  logic [N-1:0]  w_amp;
  logic          w_above;
  assign w_y_neg = ~Y + 1'b1;
  assign w_amp   = !Y[N-1]      ? Y       :
                   (Y == Y_MIN) ? AMP_MAX : w_y_neg;
  assign w_above = (w_amp >= threshold);

  // The index compares use one extra bit so that k+1 cannot wrap to zero.
  logic [T:0]    w_k_next;
  logic          w_at_timeout;
  logic          w_past_blank;
  assign w_k_next     = {1'b0, r_k} + 1'b1;
  assign w_at_timeout = (w_k_next >= {1'b0, timeout});
  assign w_past_blank = (w_k_next >= {1'b0, blank});

  // Outside DONE the run counter stays below CONFIRM, so the increment
  // cannot overflow RW bits.
  logic [RW-1:0] w_run_inc;
  logic          w_detect;
  logic [T-1:0]  w_run_start;
  assign w_run_inc   = r_run + 1'b1;
  assign w_detect    = w_above && (w_run_inc == RW'(CONFIRM));
  assign w_run_start = (r_run == '0) ? r_k : r_run_start;

  // Measurement state machine with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_run       <= '0;
      r_run_start <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_hit       <= 1'b0;
      r_tof       <= '0;
`ifdef ECHO_PEAK_EN
      r_peak      <= '0;
`endif
    end else begin
      // NOTE: done gets a default of 0 here and is raised only on the
      // decisive sample, so it is a one-cycle pulse with no clear logic.
      // All state updates use non-blocking assignment, so every branch
      // reads the values from before the edge.
      r_done <= 1'b0;
      if (start) begin
        // start wins over a coincident en, and it aborts any measurement
        // in progress without a done pulse.
        r_state     <= S_BLANK;
        r_k         <= '0;
        r_run       <= '0;
        r_run_start <= '0;
        r_busy      <= 1'b1;
        r_hit       <= 1'b0;
        r_tof       <= '0;
`ifdef ECHO_PEAK_EN
        r_peak      <= '0;
`endif
      end else begin
        case (r_state)
          S_BLANK: begin
            if (en) begin
              r_k <= w_k_next[T-1:0];
              if (w_at_timeout) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_hit   <= 1'b0;
                r_tof   <= '1;
              end else if (w_past_blank) begin
                r_state <= S_SEARCH;
              end
            end
          end
          S_SEARCH: begin
            if (en) begin
              r_k <= w_k_next[T-1:0];
`ifdef ECHO_PEAK_EN
              if (w_amp > r_peak) r_peak <= w_amp;
`endif
              if (w_detect) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_hit   <= 1'b1;
                r_tof   <= w_run_start;
              end else if (w_at_timeout) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_hit   <= 1'b0;
                r_tof   <= '1;
              end else begin
                r_run       <= w_above ? w_run_inc : '0;
                r_run_start <= w_run_start;
              end
            end
          end
          default: begin
            // IDLE and DONE ignore en and hold their results.
          end
        endcase
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hit  = r_hit;
  assign tof  = r_tof;
`ifdef ECHO_PEAK_EN
  assign peak = r_peak;
`endif

endmodule

// File: tb/tb_sonar_echo_detect.sv
// Testbench for sonar_echo_detect. Each measurement's result is predicted
// from its sample list with a sliding-window search. The bench then drives
// the samples with random en gaps and compares the DUT against that result.
// Define ECHO_PEAK_EN to build and check the peak output as well.
module tb_sonar_echo_detect;

  localparam int N    = 16;
  localparam int T    = 16;
  localparam int C    = 2;
  localparam int MAXS = 128;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         en;
  logic [N-1:0] Y;
  logic [N-1:0] threshold;
  logic [T-1:0] blank;
  logic [T-1:0] timeout;
  logic         busy;
  logic         done;
  logic         hit;
  logic [T-1:0] tof;
`ifdef ECHO_PEAK_EN
  logic [N-1:0] peak;
`endif

  sonar_echo_detect #(.N(N), .T(T), .CONFIRM(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .en        (en),
    .Y         (Y),
    .threshold (threshold),
    .blank     (blank),
    .timeout   (timeout),
    .busy      (busy),
    .done      (done),
    .hit       (hit),
`ifdef ECHO_PEAK_EN
    .peak      (peak),
`endif
    .tof       (tof)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic signed [N-1:0] smp [MAXS];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int amp_of(input logic signed [N-1:0] y);
    int a;
    a = y;
    if (a < 0) a = -a;
    if (a > 32767) a = 32767;
    return a;
  endfunction

  // Expected result from the sample list. Samples below max(blank,1) are
  // never evaluated. Detection is the first window of C at-or-above
  // samples, all of them evaluated, that ends no later than sample
  // timeout-1.
  task automatic predict(input int bl, input int to, input int thr,
                         output int d, output int h, output int tf, output int pk);
    int b;
    int all_above;
    b  = (bl == 0) ? 1 : bl;
    pk = 0;
    h  = 0;
    tf = 65535;
    if (to <= b) begin
      d = (to == 0) ? 0 : to - 1;
    end else begin
      d = to - 1;
      for (int k = b; k < to; k++) begin
        if (amp_of(smp[k]) > pk) pk = amp_of(smp[k]);
        if (k - C + 1 >= b) begin
          all_above = 1;
          for (int j = k - C + 1; j <= k; j++)
            if (amp_of(smp[j]) < thr) all_above = 0;
          if (all_above != 0) begin
            h  = 1;
            tf = k - C + 1;
            d  = k;
            break;
          end
        end
      end
    end
  endtask

  // Drive one clock cycle and return 1 time unit after the rising edge.
  task automatic step(input logic s, input logic e, input logic [N-1:0] y);
    start = s;
    en    = e;
    Y     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    en    = 1'b0;
  endtask

  task automatic fill_zero();
    for (int i = 0; i < MAXS; i++) smp[i] = '0;
  endtask

  task automatic fill_random(input int thr);
    int r;
    int a;
    for (int i = 0; i < MAXS; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        smp[i] = 16'sh8000;
      end else begin
        if (r < 35) a = $urandom_range(32767, thr);
        else        a = $urandom_range(thr - 1, 0);
        if ($urandom_range(1, 0) == 1) a = -a;
        smp[i] = 16'(a);
      end
    end
  endtask

  // One measurement. abort_at >= 0 stops driving just before that sample,
  // which leaves the DUT mid-measurement. collide raises en together with
  // start.
  task automatic run_measure(input int bl, input int to, input int thr,
                             input int abort_at, input bit collide,
                             input bit gaps, input string nm);
    int d, h, tf, pk;
    predict(bl, to, thr, d, h, tf, pk);
    blank     = T'(bl);
    timeout   = T'(to);
    threshold = N'(thr);
    step(1'b1, collide, 16'h7fff);
    check({nm, ".start_busy"}, busy, 1);
    check({nm, ".start_done"}, done, 0);
    check({nm, ".start_hit"},  hit,  0);
    check({nm, ".start_tof"},  tof,  0);
`ifdef ECHO_PEAK_EN
    check({nm, ".start_peak"}, peak, 0);
`endif
    for (int k = 0; k <= d; k++) begin
      if (gaps) begin
        repeat ($urandom_range(2, 0)) begin
          step(1'b0, 1'b0, 16'($urandom));
          check({nm, ".gap_done"}, done, 0);
        end
      end
      if (k == abort_at) return;
      step(1'b0, 1'b1, smp[k]);
      if (k < d) begin
        check({nm, ".mid_done"}, done, 0);
        check({nm, ".mid_busy"}, busy, 1);
      end else begin
        check({nm, ".done"},  done, 1);
        check({nm, ".busy"},  busy, 0);
        check({nm, ".hit"},   hit,  h);
        check({nm, ".tof"},   tof,  tf);
`ifdef ECHO_PEAK_EN
        check({nm, ".peak"},  peak, pk);
`endif
      end
    end
    step(1'b0, 1'b0, 16'h0);
    check({nm, ".pulse_end"}, done, 0);
    check({nm, ".hit_held"},  hit,  h);
    step(1'b0, 1'b1, 16'h8000);
    check({nm, ".en_in_done"},  done, 0);
    check({nm, ".busy_done"},   busy, 0);
    check({nm, ".tof_held"},    tof,  tf);
  endtask

  task automatic fill_basic();
    fill_zero();
    smp[10] = 16'sd1200;
    smp[11] = 16'sd1200;
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    en        = 1'b0;
    Y         = '0;
    threshold = '0;
    blank     = '0;
    timeout   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.hit",  hit,  0);
    check("reset.tof",  tof,  0);
    rst = 1'b1;
    step(1'b0, 1'b1, 16'h7fff);
    check("idle_en.busy", busy, 0);
    check("idle_en.done", done, 0);

    // Basic detect.
    fill_basic();
    run_measure(4, 100, 1000, -1, 1'b0, 1'b0, "basic");

    // Negative full-scale input saturates to 32767.
    fill_zero();
    smp[5] = 16'sh8000;
    smp[6] = 16'sh8000;
    run_measure(0, 100, 32767, -1, 1'b0, 1'b0, "sat");

    // Hits inside blanking are ignored, and a broken run restarts.
    fill_zero();
    smp[2]  = 16'sd2000;
    smp[3]  = 16'sd2000;
    smp[7]  = 16'sd2000;
    smp[9]  = -16'sd2000;
    smp[10] = 16'sd2000;
    run_measure(4, 100, 1000, -1, 1'b0, 1'b0, "broken");

    // Timeout.
    fill_zero();
    run_measure(4, 20, 1000, -1, 1'b0, 1'b0, "timeout");

    // Abort mid-SEARCH at k=30, then restart with a coincident en.
    fill_zero();
    run_measure(4, 100, 1000, 30, 1'b0, 1'b0, "abort");
    fill_basic();
    run_measure(4, 100, 1000, -1, 1'b1, 1'b0, "collide");

    // Asynchronous reset mid-BLANK.
    fill_zero();
    run_measure(50, 100, 1000, 5, 1'b0, 1'b0, "pre_rst");
    #1 rst = 1'b0;
    #1;
    check("arst.busy", busy, 0);
    check("arst.done", done, 0);
    check("arst.hit",  hit,  0);
    check("arst.tof",  tof,  0);
`ifdef ECHO_PEAK_EN
    check("arst.peak", peak, 0);
`endif
    #3 rst = 1'b1;
    repeat (3) begin
      step(1'b0, 1'b1, 16'h7fff);
      check("arst_en.busy", busy, 0);
      check("arst_en.done", done, 0);
    end
    fill_basic();
    run_measure(4, 100, 1000, -1, 1'b0, 1'b1, "post_rst");

    // Randomized measurements.
    for (int it = 0; it < 40; it++) begin
      int thr;
      thr = $urandom_range(30000, 100);
      fill_random(thr);
      run_measure($urandom_range(10, 0), $urandom_range(60, 0), thr,
                  -1, 1'($urandom_range(1, 0)), 1'b1, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sonar_echo_detect.md
# sonar_echo_detect

Downstream consumer of the FIR filter output in the sonar receive chain. Once per ping it takes the filtered sample stream and measures time-of-flight, reported as a sample count. It rectifies each sample, ignores a programmable blanking window after transmit, then declares an echo when CONFIRM consecutive samples reach a threshold. The result, a done pulse and a timeout indication are presented to the register/IRQ logic.

## Interface
Parameters:
- N, 16: sample width; must match the FIR data width.
- T, 16: width of the sample-index counter and the configuration fields.
- CONFIRM, 2: number of consecutive at-or-above-threshold samples required for detection; minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a measurement.
- en  in  1  sample strobe; the same strobe that drives the FIR en.
- Y  in  N  FIR output, two's complement; sampled only on en cycles.
- threshold  in  N  unsigned detection level.
- blank  in  T  number of samples ignored after start.
- timeout  in  T  maximum number of samples per measurement, blanking included.
- busy  out  1  high in BLANK and SEARCH.
- done  out  1  one-cycle pulse when a measurement finishes.
- hit  out  1  1 = echo found, 0 = timed out; held until the next start.
- tof  out  T  index of the first sample of the confirming run; all-ones on timeout; held.
- peak  out  N  maximum rectified amplitude seen in SEARCH; present only with the macro.

## Operation
- States:
  - IDLE: after reset.
  - BLANK.
  - SEARCH.
  - DONE: behaves like IDLE but keeps results.
- Sample index k: number of en strobes accepted since start. The first en after start is k=0. Register is T bits and is cleared by start.
- Rectify: amp = |Y|. Y = -2^(N-1) saturates to 2^(N-1)-1. Compare is unsigned amp >= threshold.
- start in any state:
  - next state BLANK;
  - clear k, run counter, peak, hit and tof;
  - a start during BLANK or SEARCH aborts the measurement and restarts it, with no done pulse.
- start and en in the same cycle: start wins and the sample is discarded.
- BLANK, on each en with index k:
  - if k+1 >= timeout: go to DONE with the timeout result;
  - else if k+1 >= blank: go to SEARCH;
  - k increments in both cases.
  - blank = 0 means SEARCH is entered on the first en; sample 0 is not evaluated.
- SEARCH, on each en with index k:
  - if amp >= threshold, run = run+1; otherwise run = 0;
  - record run_start = k when run goes 0 -> 1;
  - if the new run == CONFIRM: go to DONE, hit = 1, tof = run_start;
  - else if k+1 >= timeout: go to DONE, hit = 0, tof = all-ones;
  - detection has priority over timeout on the same sample.
- Run counter is ceil(log2(CONFIRM+1)) bits wide and never exceeds CONFIRM.
- en strobes in IDLE or DONE are ignored.

## Timing
- Reset values: busy=0, done=0, hit=0, tof=0, peak=0; state IDLE; all counters 0.
- start registered at edge t: busy=1 from t+1.
- Decisive en at edge t:
  - done=1 for cycle t+1 only;
  - busy=0, hit and tof valid from t+1.
- Y is sampled on the en cycle itself. The FIR updates Y 4 clocks after its own en, so each en here sees the previous sample period's output. This one-sample offset is part of the tof definition, and software compensates for it.
- Reset asserted mid-measurement returns the block to IDLE immediately with all outputs at reset values. No done pulse is emitted.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- ECHO_PEAK_EN defined:
  - peak port and register exist;
  - peak = max(peak, amp) on every evaluated SEARCH sample, including the detecting one;
  - peak is held in DONE and cleared by start.
- ECHO_PEAK_EN undefined: the peak port and its logic are omitted entirely, and all other behaviour is identical.

## Test plan
- Basic detect: blank=4, timeout=100, threshold=1000, CONFIRM=2. Y=0 except Y=1200 at k=10,11 -> done one cycle after the en of k=11, hit=1, tof=10.
- Negative and saturating rectify: Y=-32768 at k=5,6, threshold=32767, blank=0 -> hit=1, tof=5; with ECHO_PEAK_EN, peak=32767.
- Broken run and blanking: Y=2000 at k=2,3 (inside blank=4), then at k=7, 9 and 10 -> run resets at k=8; tof=9.
- Timeout: timeout=20, no sample above threshold -> done after the en of k=19, hit=0, tof=0xFFFF, busy=0.
- Restart and collision: start mid-SEARCH at k=30 -> no done, k restarts at 0. start in the same cycle as en -> that sample is not counted.
- Async reset: rst low for half a cycle mid-BLANK -> all outputs 0 and state IDLE immediately; en strobes are then ignored until the next start.
